// File: rtl/seq_div_if.sv
// Operand/result handshake bundle for the sequential divider.
// The master drives operands and out_ready; the slave (the divider) drives the results.
interface seq_div_if #(
    parameter int WIDTH = 16
);
    logic                   in_valid;
    logic                   in_ready;
    logic [2*WIDTH-1:0]     dividend;
    logic [WIDTH-1:0]       divisor;
    logic                   out_valid;
    logic                   out_ready;
    logic [WIDTH-1:0]       quotient;
    logic [WIDTH-1:0]       remainder;
    logic                   div_by_zero;
    logic                   overflow;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero, overflow
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero, overflow
    );
endinterface

// File: rtl/seq_div.sv
// Restoring divider: a 2*WIDTH-bit dividend divided by a WIDTH-bit divisor, one quotient bit per clock.
// Division by zero and quotient overflow are detected at acceptance and answered without iterating.
module seq_div #(
    parameter int WIDTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    seq_div_if.slave    bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // Partial remainder is always below the divisor, so its top bit is never needed.
    logic [WIDTH-1:0]   r_p;
    logic [WIDTH-1:0]   r_s;
    logic [WIDTH-1:0]   r_divisor;
    logic [WIDTH-1:0]   r_quot;
    logic [WIDTH-1:0]   r_rem;
    logic [CW-1:0]      r_cnt;
    logic               r_dbz;
    logic               r_ovf;

    logic [WIDTH-1:0]   w_hi;
    logic [WIDTH-1:0]   w_lo;
    logic               w_zero;
    logic               w_big;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_trial;
    logic               w_fits;
    logic [WIDTH-1:0]   w_p_next;
    logic               w_last;

    assign w_hi     = bus.dividend[2*WIDTH-1:WIDTH];
    assign w_lo     = bus.dividend[WIDTH-1:0];
    assign w_zero   = (bus.divisor == '0);
    assign w_big    = (w_hi >= bus.divisor);

    // shift < 2*divisor, so the top bit of the trial difference is a clean sign bit.
    assign w_shift  = {r_p, r_s[WIDTH-1]};
    assign w_trial  = w_shift - {1'b0, r_divisor};
    assign w_fits   = ~w_trial[WIDTH];
    assign w_p_next = w_fits ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
    assign w_last   = (r_cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (bus.in_valid) begin
                    w_state_next = (w_zero || w_big) ? DONE : CALC;
                end
            end
            CALC: begin
                if (w_last) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_p       <= '0;
            r_s       <= '0;
            r_divisor <= '0;
            r_quot    <= '0;
            r_rem     <= '0;
            r_cnt     <= '0;
            r_dbz     <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_divisor <= bus.divisor;
                        r_cnt     <= '0;
                        if (w_zero) begin
                            r_dbz  <= 1'b1;
                            r_ovf  <= 1'b0;
                            r_quot <= '1;
                            r_rem  <= w_lo;
                        end else if (w_big) begin
                            r_dbz  <= 1'b0;
                            r_ovf  <= 1'b1;
                            r_quot <= '1;
                            r_rem  <= '0;
                        end else begin
                            r_dbz  <= 1'b0;
                            r_ovf  <= 1'b0;
                            r_p    <= w_hi;
                            r_s    <= w_lo;
                            r_quot <= '0;
                            r_rem  <= '0;
                        end
                    end
                end
                CALC: begin
                    r_p    <= w_p_next;
                    r_s    <= {r_s[WIDTH-2:0], 1'b0};
                    r_quot <= {r_quot[WIDTH-2:0], w_fits};
                    r_cnt  <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_rem <= w_p_next;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.in_ready    = (r_state == IDLE);
    assign bus.out_valid   = (r_state == DONE);
    assign bus.quotient    = r_quot;
    assign bus.remainder   = r_rem;
    assign bus.div_by_zero = r_dbz;
    assign bus.overflow    = r_ovf;
endmodule
